// File: rtl/c1_serial_addsub.sv
// Digit-serial one's-complement adder/subtractor with end-around carry.
// Pass 1 adds A+B+carry_in DIGIT bits per clock, LSB digit first; if it
// carries out of the MSB, pass 2 re-walks the result adding the carry back in.
module c1_serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             eac,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned ND = WIDTH / DIGIT;
  localparam int unsigned CW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_EAC,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             eac_q, eac_d;

  logic [DIGIT-1:0]       opa, opb, dsum;
  logic                   dcarry;
  logic                   cy;
  logic [WIDTH+DIGIT-1:0] shift_cat;
  logic [WIDTH-1:0]       res_shift;
  logic                   ovf_c, zero_c;

  // Select the current operand digits; the EAC pass adds the carry to the pass-1 result
  always_comb begin
    opa = '0;
    opb = '0;
    for (int unsigned i = 0; i < ND; i++) begin
      if (cnt_q == CW'(i)) begin
        opa = a_q[i*DIGIT +: DIGIT];
        opb = b_q[i*DIGIT +: DIGIT];
      end
    end
    if (state_q == S_EAC) begin
      opa = res_q[DIGIT-1:0];
      opb = '0;
    end
  end

  // DIGIT-wide ripple full-adder chain seeded by the carry flop
  always_comb begin
    dsum = '0;
    cy   = c_q;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      dsum[i] = opa[i] ^ opb[i] ^ cy;
      cy      = (opa[i] & opb[i]) | (cy & (opa[i] ^ opb[i]));
    end
    dcarry = cy;
  end

  // New digit enters the result register at the MSB end; after ND shifts it is in place
  always_comb begin
    shift_cat = {dsum, res_q};
    res_shift = shift_cat[WIDTH+DIGIT-1:DIGIT];
  end

  // Next-state and datapath next values
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    eac_d   = eac_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = carry_in;
          cnt_d   = '0;
          eac_d   = 1'b0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        res_d = res_shift;
        c_d   = dcarry;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (dcarry) begin
            eac_d   = 1'b1;
            c_d     = 1'b1;
            state_d = S_EAC;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_EAC: begin
        res_d = res_shift;
        c_d   = dcarry;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Flags computed on the value about to be published
  always_comb begin
    ovf_c  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
    zero_c = (res_d == '0) || (res_d == '1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Operand, result, counter and carry registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
      c_q   <= 1'b0;
      eac_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      c_q   <= c_d;
      eac_q <= eac_d;
    end
  end

  // Registered status and result; result/flags only change on entry to FIN
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      sum  <= '0;
      eac  <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      busy <= (state_d == S_ADD) || (state_d == S_EAC);
      done <= (state_d == S_FIN);
      if (state_d == S_FIN) begin
        sum  <= res_d;
        eac  <= eac_d;
        ovf  <= ovf_c;
        zero <= zero_c;
      end
    end
  end

endmodule

// File: tb/tb_c1_serial_addsub.sv
// Scoreboard bench for c1_serial_addsub: (8,2) directed/random, (4,1) and (4,4) exhaustive.
module tb_c1_serial_addsub;

  typedef struct {
    logic [7:0] s;
    logic       e;
    logic       o;
    logic       z;
    int         lat;
    int         t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic       st[3], sb[3], ci[3];
  logic       bz[3], dn[3], ea[3], ov[3], zr[3];
  logic [7:0] a0, b0;
  logic [3:0] a1, b1, a2, b2;
  logic [7:0] sum0;
  logic [3:0] sum1, sum2;
  logic [7:0] sm[3];

  assign sm[0] = sum0;
  assign sm[1] = {4'h0, sum1};
  assign sm[2] = {4'h0, sum2};

  c1_serial_addsub #(.WIDTH(8), .DIGIT(2)) u_d82 (
    .clk(clk), .rst(rst), .start(st[0]), .sub(sb[0]), .a(a0), .b(b0), .carry_in(ci[0]),
    .busy(bz[0]), .done(dn[0]), .sum(sum0), .eac(ea[0]), .ovf(ov[0]), .zero(zr[0]));

  c1_serial_addsub #(.WIDTH(4), .DIGIT(1)) u_d41 (
    .clk(clk), .rst(rst), .start(st[1]), .sub(sb[1]), .a(a1), .b(b1), .carry_in(ci[1]),
    .busy(bz[1]), .done(dn[1]), .sum(sum1), .eac(ea[1]), .ovf(ov[1]), .zero(zr[1]));

  c1_serial_addsub #(.WIDTH(4), .DIGIT(4)) u_d44 (
    .clk(clk), .rst(rst), .start(st[2]), .sub(sb[2]), .a(a2), .b(b2), .carry_in(ci[2]),
    .busy(bz[2]), .done(dn[2]), .sum(sum2), .eac(ea[2]), .ovf(ov[2]), .zero(zr[2]));

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(string nm, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic int qsize(int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(int k, exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic exp_t qpop(int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic qclear(int k);
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  function automatic exp_t mk(logic [7:0] s, logic e, logic o, logic z, int lat);
    exp_t r;
    r.s = s; r.e = e; r.o = o; r.z = z; r.lat = lat; r.t0 = 0;
    return r;
  endfunction

  // Reference: sum = ((A + B' + cin) mod 2^w + eac) mod 2^w, B' = sub ? ~b : b
  function automatic exp_t model(int w, int d, logic [7:0] a, logic [7:0] b, logic sub, logic cin);
    exp_t r;
    int mask, aa, bb, s1, e, s;
    mask = (1 << w) - 1;
    aa   = int'(a) & mask;
    bb   = (sub ? ~int'(b) : int'(b)) & mask;
    s1   = aa + bb + int'(cin);
    e    = (s1 >> w) & 1;
    s    = (s1 + e) & mask;
    r.s  = 8'(s);
    r.e  = (e != 0);
    r.o  = (((aa >> (w-1)) & 1) == ((bb >> (w-1)) & 1)) && (((s >> (w-1)) & 1) != ((aa >> (w-1)) & 1));
    r.z  = (s == 0) || (s == mask);
    r.lat = (e != 0) ? 2*(w/d) + 1 : (w/d) + 1;
    r.t0 = 0;
    return r;
  endfunction

  task automatic drive(int k, logic [7:0] a, logic [7:0] b);
    case (k)
      0:       begin a0 = a;      b0 = b;      end
      1:       begin a1 = a[3:0]; b1 = b[3:0]; end
      default: begin a2 = a[3:0]; b2 = b[3:0]; end
    endcase
  endtask

  // Issue one operation, push its expectation, wait (bounded) for done
  task automatic issue(int k, logic [7:0] a, logic [7:0] b, logic s, logic c, exp_t e, bit poke);
    bit got;
    @(negedge clk);
    drive(k, a, b);
    sb[k] = s;
    ci[k] = c;
    st[k] = 1'b1;
    e.t0 = cyc;
    qpush(k, e);
    @(negedge clk);
    st[k] = 1'b0;
    chk($sformatf("d%0d_busy_in_add", k), int'(bz[k]), 1);
    if (poke) begin
      drive(k, ~a, ~b);
      sb[k] = ~s;
      ci[k] = ~c;
      @(negedge clk);
      st[k] = 1'b1;
      @(negedge clk);
      st[k] = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dn[k] === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      chk($sformatf("d%0d_done_timeout", k), 0, 1);
      qclear(k);
    end
  endtask

  // Monitor: every done pops the oldest expectation of that instance
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (dn[k] === 1'b1) begin
        if (qsize(k) == 0) begin
          chk($sformatf("d%0d_unexpected_done", k), 1, 0);
        end else begin : pop_blk
          exp_t e;
          e = qpop(k);
          chk($sformatf("d%0d_sum", k),     int'(sm[k]), int'(e.s));
          chk($sformatf("d%0d_eac", k),     int'(ea[k]), int'(e.e));
          chk($sformatf("d%0d_ovf", k),     int'(ov[k]), int'(e.o));
          chk($sformatf("d%0d_zero", k),    int'(zr[k]), int'(e.z));
          chk($sformatf("d%0d_latency", k), cyc - e.t0,  e.lat);
          chk($sformatf("d%0d_busy_in_fin", k), int'(bz[k]), 0);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; sb[k] = 1'b0; ci[k] = 1'b0;
    end
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;

    // Reset for two cycles with start held high: start must be ignored
    rst = 1'b1;
    st[0] = 1'b1; a0 = 8'h11; b0 = 8'h22;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bz[0]), 0);
    chk("rst_done", int'(dn[0]), 0);
    chk("rst_sum",  int'(sum0),  0);
    chk("rst_eac",  int'(ea[0]), 0);
    chk("rst_ovf",  int'(ov[0]), 0);
    chk("rst_zero", int'(zr[0]), 0);
    rst = 1'b0;
    st[0] = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(bz[0]), 0);
    @(negedge clk);
    chk("idle_done", int'(dn[0]), 0);

    // Directed (8,2), hand-computed
    issue(0, 8'h05, 8'h03, 1'b0, 1'b0, mk(8'h08, 0, 0, 0, 5), 0);
    issue(0, 8'h05, 8'h03, 1'b1, 1'b0, mk(8'h02, 1, 0, 0, 9), 0);
    issue(0, 8'h05, 8'h05, 1'b1, 1'b0, mk(8'hFF, 0, 0, 1, 5), 0);
    issue(0, 8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h80, 0, 1, 0, 5), 0);
    issue(0, 8'hFF, 8'hFF, 1'b0, 1'b1, mk(8'h00, 1, 1, 1, 9), 0);
    issue(0, 8'h00, 8'h00, 1'b0, 1'b0, mk(8'h00, 0, 0, 1, 5), 0);
    issue(0, 8'h80, 8'h7F, 1'b1, 1'b0, mk(8'h01, 1, 1, 0, 9), 0);
    issue(0, 8'h3C, 8'hC3, 1'b0, 1'b0, mk(8'hFF, 0, 0, 1, 5), 0);
    issue(0, 8'h12, 8'h34, 1'b0, 1'b1, mk(8'h47, 0, 0, 0, 5), 0);

    // Directed (4,4): single-digit pass
    issue(2, 8'h07, 8'h01, 1'b0, 1'b0, mk(8'h08, 0, 1, 0, 2), 0);
    issue(2, 8'h0F, 8'h0F, 1'b0, 1'b1, mk(8'h00, 1, 1, 1, 3), 0);

    // Exhaustive sweeps for (4,1) and (4,4)
    for (int k = 1; k < 3; k++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          for (int m = 0; m < 4; m++)
            issue(k, 8'(x), 8'(y), m[1], m[0],
                  model(4, (k == 1) ? 1 : 4, 8'(x), 8'(y), m[1], m[0]), 0);

    // Restart and input changes while busy must not disturb the operation
    issue(0, 8'h40, 8'h40, 1'b0, 1'b0, mk(8'h80, 0, 1, 0, 5), 1);

    // Reset in the middle of pass 1: outputs clear, no done follows
    @(negedge clk);
    a0 = 8'hAA; b0 = 8'h55; sb[0] = 1'b0; ci[0] = 1'b1; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(bz[0]), 0);
    chk("midrst_done", int'(dn[0]), 0);
    chk("midrst_sum",  int'(sum0),  0);
    chk("midrst_ovf",  int'(ov[0]), 0);
    chk("midrst_d44_sum", int'(sum2), 0);
    repeat (12) @(negedge clk);
    chk("midrst_still_idle", int'(bz[0]), 0);

    // Random (8,2) against the reference formula
    repeat (150) begin
      logic [7:0] ra, rb;
      logic       rs, rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      issue(0, ra, rb, rs, rc, model(8, 2, ra, rb, rs, rc), 0);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drain", q0.size() + q1.size() + q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
